// File: rtl/counter_buf_flusher_if.sv
// Command, counter-SRAM and EMIF write signals of the counter buffer flusher.
// The flusher drives the master side; the SRAM/EMIF/controller environment is the slave.
interface counter_buf_flusher_if #(
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 10,
  parameter int LINE_W      = 512,
  parameter int MEM_ADDR_W  = 46
);
  logic                     start;
  logic [1:0]               mode;
  logic [MEM_ADDR_W-1:0]    buffer_addr;
  logic [SRAM_ADDR_W:0]     num_lines;
  logic                     busy;
  logic                     done;
  logic                     hold_reqfifo;

  logic [SRAM_ADDR_W-1:0]   buf_rdaddress;
  logic [SRAM_DATA_W-1:0]   buf_q;
  logic [SRAM_ADDR_W-1:0]   buf_wraddress;
  logic [SRAM_DATA_W-1:0]   buf_data;
  logic                     buf_wren;

  logic                     mem_wr_valid;
  logic                     mem_wr_ready;
  logic [MEM_ADDR_W-1:0]    mem_address;
  logic [LINE_W-1:0]        mem_writedata;
  logic [LINE_W/8-1:0]      mem_byteenable;

  modport master (
    input  start, mode, buffer_addr, num_lines, buf_q, mem_wr_ready,
    output busy, done, hold_reqfifo,
    output buf_rdaddress, buf_wraddress, buf_data, buf_wren,
    output mem_wr_valid, mem_address, mem_writedata, mem_byteenable
  );

  modport slave (
    output start, mode, buffer_addr, num_lines, buf_q, mem_wr_ready,
    input  busy, done, hold_reqfifo,
    input  buf_rdaddress, buf_wraddress, buf_data, buf_wren,
    input  mem_wr_valid, mem_address, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/counter_buf_flusher.sv
// Counter SRAM flusher: zeroes the page-access-counter SRAM, or packs counters
// into EMIF lines and writes them to DRAM, optionally clearing each counter as it is read.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a start strobe with a non-NOP mode
// S_ZERO_WR | writing 0 to one SRAM address per cycle over the full depth
// S_FETCH   | issuing WPL consecutive SRAM reads for the current line
// S_DRAIN   | capturing the last read word of the line
// S_DUMP    | presenting the packed line on EMIF until accepted
// S_DONE    | one-cycle done pulse, then back to idle
module counter_buf_flusher #(
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 10,
  parameter int LINE_W      = 512,
  parameter int MEM_ADDR_W  = 46
) (
  input logic                  mclk,
  input logic                  reset,
  counter_buf_flusher_if.master bus
);

  localparam int WPL       = LINE_W / SRAM_DATA_W;
  localparam int LANE_W    = $clog2(WPL);
  localparam int DEPTH     = 2 ** SRAM_ADDR_W;
  localparam int MAX_LINES = DEPTH / WPL;
  localparam int CNT_W     = SRAM_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO_WR,
    S_FETCH,
    S_DRAIN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 sram_addr;
  logic [CNT_W-1:0]                 line_idx;
  logic [CNT_W-1:0]                 num_lines_r;
  logic [MEM_ADDR_W-1:0]            buffer_addr_r;
  logic                             clear_r;
  logic                             cap_vld;
  logic [LANE_W-1:0]                cap_lane;
  logic [WPL-1:0][SRAM_DATA_W-1:0]  line_buf;

  logic                             busy_r;
  logic                             done_r;
  logic [SRAM_ADDR_W-1:0]           rdaddr_r;
  logic [SRAM_ADDR_W-1:0]           wraddr_r;
  logic                             wren_r;
  logic                             valid_r;
  logic [MEM_ADDR_W-1:0]            maddr_r;
  logic [LINE_W/8-1:0]              be_r;

  logic [CNT_W-1:0]                 num_lines_clamped;
  logic                             last_lane;
  logic                             last_line;

  assign num_lines_clamped = (bus.num_lines > CNT_W'(MAX_LINES)) ? CNT_W'(MAX_LINES)
                                                                  : bus.num_lines;
  // Lines start on WPL-aligned addresses, so the lane is the low address bits.
  assign last_lane = &rdaddr_r[LANE_W-1:0];
  assign last_line = (line_idx + CNT_W'(1)) == num_lines_r;

  always_ff @(posedge mclk) begin
    if (reset) begin
      state         <= S_IDLE;
      sram_addr     <= '0;
      line_idx      <= '0;
      num_lines_r   <= '0;
      buffer_addr_r <= '0;
      clear_r       <= 1'b0;
      cap_vld       <= 1'b0;
      cap_lane      <= '0;
      line_buf      <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rdaddr_r      <= '0;
      wraddr_r      <= '0;
      wren_r        <= 1'b0;
      valid_r       <= 1'b0;
      maddr_r       <= '0;
      be_r          <= '0;
    end else begin
      done_r  <= 1'b0;
      wren_r  <= 1'b0;
      cap_vld <= 1'b0;

      // SRAM data lags the read address by one cycle; land it in its lane.
      if (cap_vld) begin
        line_buf[cap_lane] <= bus.buf_q;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.mode == 2'd1) begin
              state     <= S_ZERO_WR;
              busy_r    <= 1'b1;
              wren_r    <= 1'b1;
              wraddr_r  <= '0;
              sram_addr <= CNT_W'(1);
            end else if (bus.mode[1]) begin
              busy_r        <= 1'b1;
              buffer_addr_r <= bus.buffer_addr;
              num_lines_r   <= num_lines_clamped;
              clear_r       <= bus.mode[0];
              line_idx      <= '0;
              rdaddr_r      <= '0;
              if (bus.num_lines == '0) begin
                state  <= S_DONE;
                done_r <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
        end

        S_ZERO_WR: begin
          if (sram_addr == CNT_W'(DEPTH)) begin
            state  <= S_DONE;
            done_r <= 1'b1;
          end else begin
            wren_r    <= 1'b1;
            wraddr_r  <= sram_addr[SRAM_ADDR_W-1:0];
            sram_addr <= sram_addr + CNT_W'(1);
          end
        end

        S_FETCH: begin
          cap_vld  <= 1'b1;
          cap_lane <= rdaddr_r[LANE_W-1:0];
          // Clear-on-read: zero the word in the same cycle it is captured.
          wren_r   <= clear_r;
          wraddr_r <= rdaddr_r;
          rdaddr_r <= rdaddr_r + SRAM_ADDR_W'(1);
          if (last_lane) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          state   <= S_DUMP;
          valid_r <= 1'b1;
          be_r    <= '1;
          maddr_r <= buffer_addr_r + MEM_ADDR_W'(line_idx);
        end

        S_DUMP: begin
          if (bus.mem_wr_ready) begin
            valid_r  <= 1'b0;
            be_r     <= '0;
            line_idx <= line_idx + CNT_W'(1);
            if (last_line) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = busy_r;
  assign bus.hold_reqfifo   = busy_r;
  assign bus.done           = done_r;
  assign bus.buf_rdaddress  = rdaddr_r;
  assign bus.buf_wraddress  = wraddr_r;
  assign bus.buf_data       = '0;
  assign bus.buf_wren       = wren_r;
  assign bus.mem_wr_valid   = valid_r;
  assign bus.mem_address    = maddr_r;
  assign bus.mem_writedata  = line_buf;
  assign bus.mem_byteenable = be_r;

endmodule
